// File: rtl/neopixel_pkg.sv
// Shared definitions for the NeoPixel multi-string driver: register map, field positions,
// FSM encoding and default timing.
package neopixel_pkg;

    localparam logic [11:0] AddrCtrl      = 12'h000;
    localparam logic [11:0] AddrStatus    = 12'h004;
    localparam logic [11:0] AddrPixelBase = 12'h100;

    localparam int unsigned CtrlStartBit = 0;
    localparam int unsigned CtrlAutoBit  = 1;
    localparam int unsigned CtrlLenLsb   = 8;

    localparam int unsigned DefNumCh   = 4;
    localparam int unsigned DefNumLeds = 30;
    localparam int unsigned DefTBit    = 120;
    localparam int unsigned DefT0H     = 35;
    localparam int unsigned DefT1H     = 65;
    localparam int unsigned DefTReset  = 30000;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StLatch
    } state_e;

    // Index of the final pixel of a frame; LEN beyond the string length is clamped.
    function automatic logic [7:0] last_pixel(input logic [7:0] len, input int unsigned num_leds);
        if (32'(len) > num_leds) begin
            return 8'(num_leds - 1);
        end
        return len - 8'd1;
    endfunction

endpackage

// File: rtl/neopixel_pixel_ram.sv
// Per-string pixel memory: one write port from the bus, one registered read port for the
// frame sequencer. Contents are deliberately not reset.
module neopixel_pixel_ram #(
    parameter int unsigned NUM_LEDS = 30,
    parameter int unsigned AddrW    = 5
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [23:0]      wdata_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [23:0]      rdata_o
);

    logic [23:0] mem_q [NUM_LEDS];
    logic [23:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        // Write-through so a colour written in the fetch cycle is not lost.
        if (we_i && (waddr_i == raddr_i)) begin
            rdata_q <= wdata_i;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/neopixel_multi_driver.sv
// APB3 peripheral driving NUM_CH WS2812-style strings in lockstep from per-string pixel
// memories; holds bus decode, frame FSM, shared counters and bit encoders.
module neopixel_multi_driver
    import neopixel_pkg::*;
#(
    parameter int unsigned NUM_CH   = DefNumCh,
    parameter int unsigned NUM_LEDS = DefNumLeds,
    parameter int unsigned T_BIT    = DefTBit,
    parameter int unsigned T0H      = DefT0H,
    parameter int unsigned T1H      = DefT1H,
    parameter int unsigned T_RESET  = DefTReset
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [31:0]       PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [NUM_CH-1:0] dout
);

    localparam int unsigned AddrW  = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int unsigned CntMax = (T_BIT > T_RESET) ? T_BIT : T_RESET;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    logic       access, ctrl_wr, pix_win, pix_ok, pix_we;
    logic [5:0] pix_ch;
    logic [7:0] pix_idx;
    logic       unused_addr;

    assign access  = PSEL & PENABLE;
    assign ctrl_wr = access & PWRITE & (PADDR[11:0] == AddrCtrl);
    assign pix_win = (PADDR[11:8] == AddrPixelBase[11:8]);
    assign pix_ch  = PADDR[7:2];
    assign pix_idx = PWDATA[31:24];
    assign pix_ok  = (32'(pix_ch) < NUM_CH) && (32'(pix_idx) < NUM_LEDS);
    assign pix_we  = access & PWRITE & pix_win & pix_ok;
    assign PSLVERR = access & PWRITE & pix_win & ~pix_ok;
    assign PREADY  = 1'b1;
    assign unused_addr = ^{PADDR[31:12], PADDR[1:0]};

    state_e                  state_q, state_d;
    logic                    auto_q, auto_d;
    logic [7:0]              len_q, len_d;
    logic [7:0]              last_q, last_d;
    logic [7:0]              pixel_q, pixel_d;
    logic [4:0]              bit_q, bit_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [15:0]             frame_cnt_q, frame_cnt_d;
    logic [NUM_CH-1:0][23:0] word_q, word_d;
    logic [NUM_CH-1:0][23:0] rdata;
    logic [NUM_CH-1:0]       dout_q, dout_d;
    logic [AddrW-1:0]        raddr;
    logic                    start;
    logic [7:0]              start_len;

    // Prefetch the next pixel while the current one shifts out; park on pixel 0 otherwise.
    assign raddr = (state_q == StSend && pixel_q != last_q) ? AddrW'(pixel_q + 8'd1) : '0;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ram
        neopixel_pixel_ram #(
            .NUM_LEDS (NUM_LEDS),
            .AddrW    (AddrW)
        ) u_ram (
            .clk_i   (PCLK),
            .we_i    (pix_we && (pix_ch == 6'(c))),
            .waddr_i (pix_idx[AddrW-1:0]),
            .wdata_i (PWDATA[23:0]),
            .raddr_i (raddr),
            .rdata_o (rdata[c])
        );
    end

    always_comb begin
        state_d     = state_q;
        auto_d      = auto_q;
        len_d       = len_q;
        last_d      = last_q;
        pixel_d     = pixel_q;
        bit_d       = bit_q;
        cnt_d       = cnt_q;
        frame_cnt_d = frame_cnt_q;
        word_d      = word_q;
        dout_d      = '0;
        start       = 1'b0;
        start_len   = 8'd0;

        if (ctrl_wr) begin
            auto_d = PWDATA[CtrlAutoBit];
            len_d  = PWDATA[CtrlLenLsb +: 8];
        end
        if (ctrl_wr && PWDATA[CtrlStartBit] && (PWDATA[CtrlLenLsb +: 8] != 8'd0)) begin
            start     = 1'b1;
            start_len = PWDATA[CtrlLenLsb +: 8];
        end else if (auto_q && (len_q != 8'd0)) begin
            start     = 1'b1;
            start_len = len_q;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSend;
                    pixel_d = 8'd0;
                    bit_d   = 5'd23;
                    cnt_d   = '0;
                    last_d  = last_pixel(start_len, NUM_LEDS);
                    word_d  = rdata;
                end
            end
            StSend: begin
                if (cnt_q == CntW'(T_BIT - 1)) begin
                    cnt_d = '0;
                    if (bit_q != 5'd0) begin
                        bit_d = bit_q - 5'd1;
                    end else if (pixel_q == last_q) begin
                        state_d = StLatch;
                    end else begin
                        pixel_d = pixel_q + 8'd1;
                        bit_d   = 5'd23;
                        word_d  = rdata;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StLatch: begin
                if (cnt_q == CntW'(T_RESET - 1)) begin
                    state_d     = StIdle;
                    cnt_d       = '0;
                    pixel_d     = 8'd0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // dout is registered from next-state values so the pins stay glitch-free.
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            dout_d[c] = (state_d == StSend) &&
                        (cnt_d < (word_d[c][bit_d] ? CntW'(T1H) : CntW'(T0H)));
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= StIdle;
            auto_q      <= 1'b0;
            len_q       <= 8'd0;
            last_q      <= 8'd0;
            pixel_q     <= 8'd0;
            bit_q       <= 5'd0;
            cnt_q       <= '0;
            frame_cnt_q <= 16'd0;
            word_q      <= '0;
            dout_q      <= '0;
        end else begin
            state_q     <= state_d;
            auto_q      <= auto_d;
            len_q       <= len_d;
            last_q      <= last_d;
            pixel_q     <= pixel_d;
            bit_q       <= bit_d;
            cnt_q       <= cnt_d;
            frame_cnt_q <= frame_cnt_d;
            word_q      <= word_d;
            dout_q      <= dout_d;
        end
    end

    assign dout = dout_q;

    always_comb begin
        PRDATA = '0;
        if (access && !PWRITE) begin
            case (PADDR[11:0])
                AddrCtrl:   PRDATA = {16'd0, len_q, 6'd0, auto_q, 1'b0};
                AddrStatus: PRDATA = {frame_cnt_q, pixel_q, 7'd0, state_q != StIdle};
                default:    PRDATA = '0;
            endcase
        end
    end

endmodule
